// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response and ALU-side signal bundle for alu_share_arbiter
// Ports: req{0,1}_* valid/ready request channels (a, b, op, binv),
//        resp{0,1}_* valid/ready response channels (result, cout),
//        alu_* operands out and result/cout in, busy and grant_id status.
// slave is the arbiter's view, master is the client/ALU/testbench view.
interface alu_share_arbiter_if #(parameter int WIDTH = 32);
    logic             req0_valid, req0_ready, req0_binv;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [1:0]       req0_op;
    logic             resp0_valid, resp0_ready, resp0_cout;
    logic [WIDTH-1:0] resp0_result;
    logic             req1_valid, req1_ready, req1_binv;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [1:0]       req1_op;
    logic             resp1_valid, resp1_ready, resp1_cout;
    logic [WIDTH-1:0] resp1_result;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [1:0]       alu_op;
    logic             alu_binv, alu_cin, alu_cout;
    logic             busy, grant_id;
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_binv, resp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, req1_binv, resp1_ready,
        input  alu_result, alu_cout,
        output req0_ready, resp0_valid, resp0_result, resp0_cout,
        output req1_ready, resp1_valid, resp1_result, resp1_cout,
        output alu_a, alu_b, alu_op, alu_binv, alu_cin, busy, grant_id
    );
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_binv, resp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, req1_binv, resp1_ready,
        output alu_result, alu_cout,
        input  req0_ready, resp0_valid, resp0_result, resp0_cout,
        input  req1_ready, resp1_valid, resp1_result, resp1_cout,
        input  alu_a, alu_b, alu_op, alu_binv, alu_cin, busy, grant_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters
// Ports: clk (rising edge), rst_n (async active-low), bus (alu_share_arbiter_if.slave) carrying
//        both request/response channels, the ALU operand/result signals, busy and grant_id.
module alu_share_arbiter #(parameter int WIDTH = 32) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state_q, state_d;
    logic             grant_q, grant_d, last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             binv_q, binv_d, cout_q, cout_d;
    logic             any, sel, idle, rsp, resp_ok;
    assign any     = bus.req0_valid | bus.req1_valid;
    // On contention the requester that did not win last time is picked.
    assign sel     = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
    assign idle    = state_q == IDLE;
    assign rsp     = state_q == RESP;
    assign resp_ok = grant_q ? bus.resp1_ready : bus.resp0_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            binv_q  <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            binv_q  <= binv_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
        end
    end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        binv_d  = binv_q;
        res_d   = res_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (any) begin
                state_d = EXEC;
                grant_d = sel;
                a_d     = sel ? bus.req1_a : bus.req0_a;
                b_d     = sel ? bus.req1_b : bus.req0_b;
                op_d    = sel ? bus.req1_op : bus.req0_op;
                binv_d  = sel ? bus.req1_binv : bus.req0_binv;
            end
            EXEC: begin
                state_d = RESP;
                res_d   = bus.alu_result;
                cout_d  = bus.alu_cout;
            end
            RESP: if (resp_ok) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // Ready is gated by rst_n so every output reads 0 while reset is held.
    assign bus.req0_ready   = rst_n & idle & any & ~sel;
    assign bus.req1_ready   = rst_n & idle & any & sel;
    assign bus.resp0_valid  = rsp & ~grant_q;
    assign bus.resp1_valid  = rsp & grant_q;
    assign bus.resp0_result = bus.resp0_valid ? res_q : '0;
    assign bus.resp1_result = bus.resp1_valid ? res_q : '0;
    assign bus.resp0_cout   = bus.resp0_valid & cout_q;
    assign bus.resp1_cout   = bus.resp1_valid & cout_q;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_op       = op_q;
    assign bus.alu_binv     = binv_q;
    assign bus.alu_cin      = binv_q;
    assign bus.busy         = ~idle;
    assign bus.grant_id     = grant_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
    localparam int W = 32;
    logic clk, rst_n;
    int   vec, errs;
    alu_share_arbiter_if #(.WIDTH(W)) bus ();
    alu_share_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic [W:0] sum;
    assign sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_binv ? ~bus.alu_b : bus.alu_b} + {{W{1'b0}}, bus.alu_cin};
    assign bus.alu_result = bus.alu_op == 2'd0 ? (bus.alu_a & bus.alu_b) :
                            bus.alu_op == 2'd1 ? (bus.alu_a | bus.alu_b) :
                            bus.alu_op == 2'd2 ? sum[W-1:0] : '0;
    assign bus.alu_cout   = bus.alu_op == 2'd2 ? sum[W] : 1'b0;
    logic        p0, p1;
    logic [66:0] s0, s1;
    always @(posedge clk) begin
        if (p0) assert ({bus.req0_a, bus.req0_b, bus.req0_op, bus.req0_binv} === s0) else begin
            errs++;
            $error("FAIL proto0: req0 fields changed while pending");
        end
        if (p1) assert ({bus.req1_a, bus.req1_b, bus.req1_op, bus.req1_binv} === s1) else begin
            errs++;
            $error("FAIL proto1: req1 fields changed while pending");
        end
        p0 <= bus.req0_valid & ~bus.req0_ready;
        p1 <= bus.req1_valid & ~bus.req1_ready;
        s0 <= {bus.req0_a, bus.req0_b, bus.req0_op, bus.req0_binv};
        s1 <= {bus.req1_a, bus.req1_b, bus.req1_op, bus.req1_binv};
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic set_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] o, input logic bi);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = o; bus.req1_binv = bi;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = o; bus.req0_binv = bi;
        end
    endtask
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                         input logic bi, input logic [W-1:0] er, input logic ec);
        set_req(id, 1'b1, a, b, o, bi);
        #1 chk("accept", {bus.req1_ready, bus.req0_ready}, id ? 2'b10 : 2'b01);
        @(negedge clk);
        chk("exec_state", {bus.busy, bus.resp1_valid, bus.resp0_valid, bus.grant_id}, {3'b100, id});
        chk("exec_alu", {bus.alu_a, bus.alu_b}, {a, b});
        chk("exec_cin", {bus.alu_op, bus.alu_binv, bus.alu_cin}, {o, bi, bi});
        set_req(id, 1'b0, a, b, o, bi);
        @(negedge clk);
        chk("resp_valid", {bus.resp1_valid, bus.resp0_valid}, id ? 2'b10 : 2'b01);
        chk("resp_data", id ? {bus.resp1_cout, bus.resp1_result} : {bus.resp0_cout, bus.resp0_result}, {ec, er});
        @(negedge clk);
        chk("back_idle", {bus.busy, bus.resp1_valid, bus.resp0_valid}, 3'b000);
    endtask
    initial begin
        vec = 0; errs = 0; p0 = 0; p1 = 0; s0 = '0; s1 = '0;
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 2'd0, 1'b0);
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        #3 chk("reset_out", {bus.busy, bus.grant_id, bus.resp0_valid, bus.resp1_valid, bus.req0_ready,
                             bus.req1_ready, bus.alu_op, bus.alu_binv, bus.alu_cin}, 10'd0);
        chk("reset_alu", {bus.alu_a, bus.alu_b}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        do_op(1'b0, 32'd5, 32'd50, 2'd0, 1'b0, 32'd0, 1'b0);
        do_op(1'b0, 32'd5, 32'd50, 2'd1, 1'b0, 32'd55, 1'b0);
        do_op(1'b0, 32'd5, 32'd50, 2'd2, 1'b0, 32'd55, 1'b0);
        do_op(1'b0, 32'd5, 32'd50, 2'd2, 1'b1, 32'hFFFF_FFD3, 1'b0);
        do_op(1'b1, 32'd50, 32'd5, 2'd2, 1'b1, 32'd45, 1'b1);
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 2'd2, 1'b0);
        set_req(1'b1, 1'b1, 32'd10, 32'd20, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("cont_grant", {bus.req1_ready, bus.req0_ready}, i[0] ? 2'b10 : 2'b01);
            @(negedge clk);
            @(negedge clk);
            chk("cont_valid", {bus.resp1_valid, bus.resp0_valid}, i[0] ? 2'b10 : 2'b01);
            chk("cont_res", {bus.resp1_result, bus.resp0_result}, i[0] ? {32'd30, 32'd0} : {32'd0, 32'd3});
            @(negedge clk);
        end
        bus.resp0_ready = 1'b0;
        #1 chk("bp_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd1, 32'd2, 2'd2, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {bus.resp0_valid, bus.busy, bus.req1_ready, bus.resp0_cout, bus.resp0_result},
                {4'b1100, 32'd3});
            @(negedge clk);
        end
        bus.resp0_ready = 1'b1;
        #1 chk("bp_release", {bus.resp0_valid, bus.req1_ready}, 2'b10);
        @(negedge clk);
        chk("bp_next", {bus.busy, bus.req1_ready, bus.req0_ready}, 3'b010);
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'd10, 32'd20, 2'd2, 1'b0);
        @(negedge clk);
        chk("bp_resp1", {bus.resp1_valid, bus.resp1_result}, {1'b1, 32'd30});
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'd7, 32'd9, 2'd2, 1'b0);
        #1 chk("rx_accept", bus.req0_ready, 1'b1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd7, 32'd9, 2'd2, 1'b0);
        rst_n = 1'b0;
        #1 chk("rx_exec_rst", {bus.busy, bus.resp0_valid, bus.alu_a, bus.alu_op}, 36'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rx_exec_drop", {bus.busy, bus.resp0_valid, bus.resp1_valid}, 3'b000);
        bus.resp0_ready = 1'b0;
        set_req(1'b0, 1'b1, 32'd7, 32'd9, 2'd2, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd7, 32'd9, 2'd2, 1'b0);
        @(negedge clk);
        chk("rr_resp", {bus.resp0_valid, bus.resp0_result}, {1'b1, 32'd16});
        #2 rst_n = 1'b0;
        #1 chk("rr_rst", {bus.busy, bus.resp0_valid, bus.resp0_result, bus.alu_b}, 66'd0);
        @(negedge clk) rst_n = 1'b1;
        bus.resp0_ready = 1'b1;
        chk("rr_drop", {bus.busy, bus.resp0_valid}, 2'b00);
        set_req(1'b1, 1'b1, 32'd50, 32'd5, 2'd2, 1'b1);
        set_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 2'd3, 1'b0);
        #1 chk("post_rst_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 2'd3, 1'b0);
        @(negedge clk);
        chk("rsvd_resp", {bus.resp0_valid, bus.resp0_cout, bus.resp0_result}, {2'b10, 32'd0});
        @(negedge clk);
        chk("post_req1", bus.req1_ready, 1'b1);
        @(negedge clk);
        chk("post_cin", {bus.alu_cin, bus.grant_id}, 2'b11);
        set_req(1'b1, 1'b0, 32'd50, 32'd5, 2'd2, 1'b1);
        @(negedge clk);
        chk("post_resp1", {bus.resp1_valid, bus.resp1_cout, bus.resp1_result}, {2'b11, 32'd45});
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational 32-bit ALU (AND/OR/ADD/SUB, 2-bit op plus B-invert) between two independent requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. The block selects one request at a time with round-robin priority, registers its operands, drives the ALU for one cycle, captures result and carry-out, and holds the response until it is accepted. It sits between the ALU instance and its client units.

Parameters:
WIDTH, 32, operand/result width in bits; ALU ports sized to match.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_op  input  2  requester 0 op: 00 AND, 01 OR, 10 ADD/SUB, 11 reserved
req0_binv  input  1  requester 0 B-invert (1 = subtract when op=10)
resp0_valid  output  1  requester 0 result available
resp0_ready  input  1  requester 0 accepts result
resp0_result  output  WIDTH  requester 0 result
resp0_cout  output  1  requester 0 carry-out
req1_* / resp1_*  same set as requester 0, for requester 1
alu_a  output  WIDTH  ALU operand A
alu_b  output  WIDTH  ALU operand B
alu_op  output  2  ALU operation
alu_binv  output  1  ALU B-invert
alu_cin  output  1  ALU carry-in, always equal to alu_binv
alu_result  input  WIDTH  ALU result, combinational
alu_cout  input  1  ALU carry-out, combinational
busy  output  1  high in any state other than IDLE
grant_id  output  1  index of the requester currently owning the ALU

Behaviour:
- Reset: all outputs are 0; state = IDLE; last_grant = 1, so requester 0 wins first. Operand, result and cout registers clear to 0. Reset is asynchronous and takes effect in any state.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: it is high only for the selected requester, and only in IDLE.
  - Selection: if one valid is high, that requester is selected. If both are high, the one not equal to last_grant is selected.
  - On a handshake, latch a, b, op and binv into operand registers, set grant_id, and move to EXEC.
  - No valid: remain in IDLE.
- EXEC (exactly one cycle):
  - alu_* outputs are driven from the operand registers. They are driven from these registers in every state, so they are stable and hold their last values outside EXEC.
  - At the end of the cycle, capture alu_result and alu_cout into the response registers. Move to RESP.
- RESP:
  - respN_valid is high only for grant_id. respN_result and respN_cout come from the response registers and stay stable while valid.
  - On resp_ready high: set last_grant = grant_id and move to IDLE.
  - Otherwise hold indefinitely; there is no timeout.
  - The other requester's valid may stay high the whole time; it is not accepted until IDLE.
- Latency and throughput:
  - Accept in cycle T; resp_valid in cycle T+2.
  - With resp_ready tied high, the earliest next accept is T+3, giving one operation per 3 cycles.
- Responses for the non-granted requester are always 0/invalid.
- Ops 10 with binv=0 and all non-add ops are passed through unchanged. The ALU defines results: op 11 yields result 0 and cout 0; AND/OR yield cout 0. The arbiter performs no arithmetic of its own.
- Width: the result is WIDTH bits. cout is the carry out of bit WIDTH-1, computed as A + ~B + 1 for subtract.
- Simultaneous events:
  - A request arriving in the same cycle as a resp handshake is not accepted that cycle. It is considered in the following IDLE cycle, using the updated last_grant.
- Reset mid-operation: the in-flight transaction is dropped with no response. After reset release, arbitration restarts with requester 0 priority.
- Requester protocol (checked by assertion in the bench): once reqN_valid is raised, a/b/op/binv stay stable until reqN_ready.

Test Plan:
- Single requester, with req0 a=5, b=50, resp0_ready=1:
  - op=00 -> result 0, cout 0
  - op=01 -> result 55, cout 0
  - op=10, binv=0 -> result 55, cout 0
  - op=10, binv=1 -> result 0xFFFFFFD3, cout 0
  - Each response must appear exactly 2 cycles after acceptance.
- Subtract with borrow-free carry: req1 a=50, b=5, op=10, binv=1 -> resp1_result=45, resp1_cout=1. alu_cin=1 during EXEC.
- Contention: both valid continuously, req0 ADD 1+2, req1 ADD 10+20, ready high -> grants alternate 0,1,0,1 starting with 0. Responses are 3 and 30 respectively, never crossed.
- Backpressure: resp0_ready low for 10 cycles while req1 is pending:
  - resp0_valid and data stay stable; busy=1; req1_ready=0 throughout.
  - After resp0_ready is asserted, req1 is accepted on the next cycle.
- Reset in EXEC and in RESP: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, and no response is issued. A fresh req1 and req0 together afterwards -> req0 is granted first.
- Reserved op: op=11, a=0xFFFFFFFF, b=1 -> result 0, cout 0, with normal handshake timing.
